// File: rtl/seq_pkg.sv
// Shared types and constants for the program sequencer and its next-PC helper.
package seq_pkg;

  localparam int unsigned ADDR_W            = 8;
  localparam int unsigned DATA_W            = 8;
  localparam int unsigned MEM_DEPTH_DEFAULT = 66;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_HALTED = 3'd3,
    ST_LOAD   = 3'd4
  } seq_state_e;

  // True when addr names a real program word.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int unsigned        depth);
    return ({{(32-ADDR_W){1'b0}}, addr} < depth);
  endfunction

endpackage

// File: rtl/pc_next.sv
// Next program counter for EXEC: wrap-around increment, jump select and jump-range check.
module pc_next
  import seq_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              halt_i,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic              jump_fault_o
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_DEPTH - 1);

  logic [ADDR_W-1:0] pc_inc;
  logic              jump_bad;

  // Wrap is an exact compare against the last word, not a power-of-two modulo.
  always_comb begin
    pc_inc   = (pc_i == LAST_PC) ? '0 : pc_i + ADDR_W'(1);
    jump_bad = !addr_in_range(jump_addr_i, MEM_DEPTH);
  end

  // Halt outranks jump; a bad jump leaves the PC where it is.
  always_comb begin
    next_pc_o = pc_inc;
    if (!halt_i && jump_en_i) begin
      next_pc_o = jump_bad ? pc_i : jump_addr_i;
    end
  end

  assign jump_fault_o = jump_bad;

endmodule

// File: rtl/program_sequencer.sv
// Program-memory sequencer: owns the PC, runs the FETCH/EXEC loop and
// arbitrates loader writes while the core is idle or halted.
//
// state   | meaning
// IDLE    | after reset, waiting for start or a load
// FETCH   | mem_addr = pc, memory latches on the next negedge
// EXEC    | code word valid, halt/jump applied
// HALTED  | stopped by halt or bad jump, waiting for start or a load
// LOAD    | one-cycle loader write, then back to IDLE/HALTED
module program_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEFAULT,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic              halt_i,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              load_req_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              load_ack_o,
  output logic              load_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              fetch_valid_o,
  output logic              running_o,
  output logic              fault_o
);

  localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);

  seq_state_e        state_q, state_d;
  seq_state_e        origin_q, origin_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;
  logic              ld_err_q, ld_err_d;

  logic [ADDR_W-1:0] exec_next_pc;
  logic              exec_jump_fault;
  logic              is_parked;

  pc_next #(
    .MEM_DEPTH (MEM_DEPTH)
  ) u_pc_next (
    .pc_i         (pc_q),
    .halt_i       (halt_i),
    .jump_en_i    (jump_en_i),
    .jump_addr_i  (jump_addr_i),
    .next_pc_o    (exec_next_pc),
    .jump_fault_o (exec_jump_fault)
  );

  assign is_parked = (state_q == ST_IDLE) || (state_q == ST_HALTED);

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      origin_q  <= ST_IDLE;
      pc_q      <= RESET_PC_A;
      fault_q   <= 1'b0;
      ld_addr_q <= '0;
      ld_data_q <= '0;
      ld_err_q  <= 1'b0;
    end else begin
      origin_q  <= origin_d;
      pc_q      <= pc_d;
      fault_q   <= fault_d;
      ld_addr_q <= ld_addr_d;
      ld_data_q <= ld_data_d;
      ld_err_q  <= ld_err_d;
    end
  end

  // Next state plus datapath updates; the load request is captured on
  // acceptance so the LOAD cycle drives memory from registers only.
  always_comb begin
    state_d   = state_q;
    origin_d  = origin_q;
    pc_d      = pc_q;
    fault_d   = fault_q;
    ld_addr_d = ld_addr_q;
    ld_data_d = ld_data_q;
    ld_err_d  = ld_err_q;
    unique case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (load_req_i) begin
          state_d   = ST_LOAD;
          origin_d  = state_q;
          ld_addr_d = load_addr_i;
          ld_data_d = load_data_i;
          ld_err_d  = !addr_in_range(load_addr_i, MEM_DEPTH);
        end else if (start_i) begin
          state_d = ST_FETCH;
          fault_d = 1'b0;
        end
      end
      ST_FETCH: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        pc_d = exec_next_pc;
        if (halt_i) begin
          state_d = ST_HALTED;
        end else if (jump_en_i && exec_jump_fault) begin
          state_d = ST_HALTED;
          fault_d = 1'b1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_LOAD: begin
        state_d = origin_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    load_ack_o    = 1'b0;
    load_err_o    = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = pc_q;
    mem_wdata_o   = '0;
    fetch_valid_o = 1'b0;
    running_o     = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        running_o = 1'b1;
      end
      ST_EXEC: begin
        running_o     = 1'b1;
        fetch_valid_o = 1'b1;
      end
      ST_LOAD: begin
        load_ack_o = 1'b1;
        load_err_o = ld_err_q;
        if (!ld_err_q) begin
          mem_we_o    = 1'b1;
          mem_addr_o  = ld_addr_q;
          mem_wdata_o = ld_data_q;
        end
      end
      default: ;
    endcase
  end

  assign pc_o    = pc_q;
  assign fault_o = fault_q;

endmodule
